regf_wb_arbiter: RTL and testbench

//  Write-back arbiter in front of the register-file write port. It merges the

---
 rtl/regf_wb_pkg.sv | 39 +++
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/wb_fifo_chk.sv | 14 +
 rtl/regf_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regf_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regf_wb_pkg.sv
// Shared types and load-result extraction for the register-file write-back arbiter.
package regf_wb_pkg;

  localparam int WB_XLEN = 32;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] value;
  } wb_entry_t;

  // Bit 0 of the offset is deliberately ignored for halfword loads.
  function automatic logic [WB_XLEN-1:0] load_extract(
    input logic [2:0]         funct3,
    input logic [1:0]         addr_lo,
    input logic [WB_XLEN-1:0] rdata
  );
    logic [7:0]         b;
    logic [15:0]        h;
    logic [WB_XLEN-1:0] r;
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LD_LB:   r = {{(WB_XLEN-8){b[7]}}, b};
      LD_LH:   r = {{(WB_XLEN-16){h[15]}}, h};
      LD_LBU:  r = {{(WB_XLEN-8){1'b0}}, b};
      LD_LHU:  r = {{(WB_XLEN-16){1'b0}}, h};
      LD_LW:   r = rdata;
      default: r = rdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; exposes per-slot valid bits and
// destination registers so the top can build the pending-write mask.
module wb_fifo
  import regf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  wb_entry_t             din,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output logic [DEPTH-1:0]      valid,
  output logic [DEPTH-1:0][4:0] slot_rd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wb_entry_t        mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign valid   = valid_q;

  // Pointer, occupancy and slot-valid next state; pointers wrap as DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop_ok) begin
      rd_ptr_d          = rd_ptr_q + PW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok) begin
      wr_ptr_d          = wr_ptr_q + PW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers and storage; reset drops every queued entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      valid_q  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (push_ok) mem_q[wr_ptr_q] <= din;
    end
  end

  // Slot destination registers for the pending-write mask.
  always_comb begin
    slot_rd = '0;
    for (int i = 0; i < DEPTH; i++) slot_rd[i] = mem_q[i].rd;
  end

  wb_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .count (count_q)
  );

endmodule

// File: rtl/wb_fifo_chk.sv
// Occupancy checker for wb_fifo: the entry count may never exceed the depth.
module wb_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic [CW-1:0] count
);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH))
    else $error("wb_fifo count above depth");

endmodule

// File: rtl/regf_wb_arbiter.sv
// Write-back arbiter: ALU results take priority, queued loads drain in order,
// and a load arriving at an empty queue bypasses straight to the output register.
module regf_wb_arbiter
  import regf_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = WB_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_value,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_addr_lo,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic            write_regf_en,
  output logic [4:0]      addr_rd,
  output logic [XLEN-1:0] rd_value,
  output logic [31:0]     busy_mask
);

  logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_entry_t                  fifo_head, ld_entry;
  logic [FIFO_DEPTH-1:0]      fifo_valid;
  logic [FIFO_DEPTH-1:0][4:0] fifo_rd;
  logic                       lsu_acc, ld_keep, alu_req;
  logic                       wen_q, wen_d;
  logic [4:0]                 addr_q, addr_d;
  logic [XLEN-1:0]            val_q, val_d;

  // Ready deliberately ignores a same-cycle pop so a full queue never accepts.
  assign lsu_ready      = rst & ~fifo_full;
  assign lsu_acc        = lsu_valid & lsu_ready;
  assign ld_keep        = lsu_acc & (lsu_rd != 5'd0);
  assign alu_req        = alu_valid & (alu_rd != 5'd0);
  assign ld_entry.rd    = lsu_rd;
  assign ld_entry.value = load_extract(lsu_funct3, lsu_addr_lo, lsu_rdata);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (ld_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head),
    .valid   (fifo_valid),
    .slot_rd (fifo_rd)
  );

  // Port arbitration: ALU, then queue head, then bypass; otherwise hold address/data.
  always_comb begin
    wen_d     = 1'b0;
    addr_d    = addr_q;
    val_d     = val_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_req) begin
      wen_d     = 1'b1;
      addr_d    = alu_rd;
      val_d     = alu_value;
      fifo_push = ld_keep;
    end else if (!fifo_empty) begin
      wen_d     = 1'b1;
      addr_d    = fifo_head.rd;
      val_d     = fifo_head.value;
      fifo_pop  = 1'b1;
      fifo_push = ld_keep;
    end else if (ld_keep) begin
      wen_d  = 1'b1;
      addr_d = ld_entry.rd;
      val_d  = ld_entry.value;
    end else begin
      wen_d = 1'b0;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q  <= 1'b0;
      addr_q <= 5'd0;
      val_q  <= {XLEN{1'b0}};
    end else begin
      wen_q  <= wen_d;
      addr_q <= addr_d;
      val_q  <= val_d;
    end
  end

  assign write_regf_en = wen_q;
  assign addr_rd       = addr_q;
  assign rd_value      = val_q;

  // Pending-write mask over queued entries only; the output register writes next edge.
  always_comb begin
    busy_mask = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (fifo_valid[i]) busy_mask[fifo_rd[i]] = 1'b1;
      else               busy_mask = busy_mask;
    end
  end

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Directed bench for regf_wb_arbiter: an extraction/selection vector table plus
// hand-written reset, collision, backpressure, x0 and full-queue sequences.
module tb_regf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic [31:0] lsu_rdata;
  logic        write_regf_en;
  logic [4:0]  addr_rd;
  logic [31:0] rd_value;
  logic [31:0] busy_mask;

  always #5 clk = ~clk;

  regf_wb_arbiter #(.FIFO_DEPTH(4), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_value     (alu_value),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_funct3    (lsu_funct3),
    .lsu_addr_lo   (lsu_addr_lo),
    .lsu_rdata     (lsu_rdata),
    .write_regf_en (write_regf_en),
    .addr_rd       (addr_rd),
    .rd_value      (rd_value),
    .busy_mask     (busy_mask)
  );

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_val;
    logic        lsu_v;
    logic [4:0]  lsu_rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[17];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_valid   = 1'b0;
    alu_rd      = 5'd0;
    alu_value   = 32'd0;
    lsu_valid   = 1'b0;
    lsu_rd      = 5'd0;
    lsu_funct3  = 3'b010;
    lsu_addr_lo = 2'd0;
    lsu_rdata   = 32'd0;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] val);
    alu_valid = v;
    alu_rd    = rd;
    alu_value = val;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] data);
    lsu_valid   = v;
    lsu_rd      = rd;
    lsu_funct3  = f3;
    lsu_addr_lo = lo;
    lsu_rdata   = data;
  endtask

  task automatic check_wr(input string name, input logic en, input logic [4:0] rd,
                          input logic [31:0] val);
    check({name, "_en"}, {31'd0, write_regf_en}, {31'd0, en});
    check({name, "_rd"}, {27'd0, addr_rd}, {27'd0, rd});
    check({name, "_val"}, rd_value, val);
  endtask

  initial begin
    //         alu_v alu_rd alu_val        lsu_v rd     f3      lo     rdata          en    rd      val
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  3'b000, 2'd2, 32'h12F45678, 1'b1, 5'd5,  32'hFFFFFFF4};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  3'b100, 2'd2, 32'h12F45678, 1'b1, 5'd5,  32'h000000F4};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  3'b101, 2'd3, 32'h12F45678, 1'b1, 5'd5,  32'h000012F4};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  3'b001, 2'd2, 32'h80017FFF, 1'b1, 5'd6,  32'hFFFF8001};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  3'b001, 2'd1, 32'h80017FFF, 1'b1, 5'd6,  32'h00007FFF};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  3'b000, 2'd1, 32'h80017FFF, 1'b1, 5'd7,  32'h0000007F};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  3'b000, 2'd0, 32'h80017FFF, 1'b1, 5'd7,  32'hFFFFFFFF};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  3'b100, 2'd3, 32'h80017FFF, 1'b1, 5'd8,  32'h00000080};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  3'b000, 2'd3, 32'h80017FFF, 1'b1, 5'd8,  32'hFFFFFF80};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  3'b010, 2'd2, 32'hCAFEF00D, 1'b1, 5'd9,  32'hCAFEF00D};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  3'b011, 2'd1, 32'hCAFEF00D, 1'b1, 5'd9,  32'hCAFEF00D};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 3'b110, 2'd3, 32'hCAFEF00D, 1'b1, 5'd10, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 3'b111, 2'd0, 32'hA55A5AA5, 1'b1, 5'd11, 32'hA55A5AA5};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 3'b101, 2'd1, 32'h8001FFFF, 1'b1, 5'd13, 32'h0000FFFF};
    vecs[14] = '{1'b1, 5'd12, 32'hDEADBEEF, 1'b0, 5'd0,  3'b010, 2'd0, 32'h0,        1'b1, 5'd12, 32'hDEADBEEF};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  3'b010, 2'd0, 32'h0,        1'b0, 5'd12, 32'hDEADBEEF};
    vecs[16] = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  3'b010, 2'd0, 32'h11111111, 1'b0, 5'd12, 32'hDEADBEEF};

    idle_in();
    rst = 1'b0;
    tick();
    tick();
    check_wr("por", 1'b0, 5'd0, 32'd0);
    check("por_ready", {31'd0, lsu_ready}, 32'd0);
    check("por_busy", busy_mask, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_ready", {31'd0, lsu_ready}, 32'd1);

    // Table: single-cycle stimulus with an empty queue, result one edge later.
    for (int i = 0; i < 17; i++) begin
      set_alu(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_val);
      set_lsu(vecs[i].lsu_v, vecs[i].lsu_rd, vecs[i].f3, vecs[i].lo, vecs[i].rdata);
      #1;
      check($sformatf("vec%0d_ready", i), {31'd0, lsu_ready}, 32'd1);
      tick();
      check_wr($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_rd, vecs[i].exp_val);
      check($sformatf("vec%0d_busy", i), busy_mask, 32'd0);
    end
    idle_in();
    tick();

    // Reset mid-stream with three queued loads.
    set_alu(1'b1, 5'd1, 32'h1);
    for (int k = 0; k < 3; k++) begin
      set_lsu(1'b1, 5'(3 + k), 3'b010, 2'd0, 32'h300 + 32'(k));
      tick();
    end
    idle_in();
    #1;
    check("rst_busy_pre", busy_mask, 32'h00000038);
    rst = 1'b0;
    #1;
    check_wr("rst_mid", 1'b0, 5'd0, 32'd0);
    check("rst_mid_busy", busy_mask, 32'd0);
    check("rst_mid_ready", {31'd0, lsu_ready}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rst_rel_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    check("rst_stale0", {31'd0, write_regf_en}, 32'd0);
    tick();
    check("rst_stale1", {31'd0, write_regf_en}, 32'd0);

    // ALU / load collision.
    set_alu(1'b1, 5'd1, 32'hA);
    set_lsu(1'b1, 5'd2, 3'b010, 2'd0, 32'hB);
    #1;
    check("col_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    idle_in();
    check_wr("col_c1", 1'b1, 5'd1, 32'hA);
    check("col_busy1", busy_mask, 32'h00000004);
    tick();
    check_wr("col_c2", 1'b1, 5'd2, 32'hB);
    check("col_busy2", busy_mask, 32'd0);
    tick();
    check("col_c3_en", {31'd0, write_regf_en}, 32'd0);

    // Backpressure under sustained ALU traffic, then in-order drain.
    for (int k = 0; k < 4; k++) begin
      set_alu(1'b1, 5'd10, 32'h1000 + 32'(k));
      set_lsu(1'b1, 5'(3 + k), 3'b010, 2'd0, 32'h100 + 32'(k));
      #1;
      check($sformatf("bp_ready%0d", k), {31'd0, lsu_ready}, 32'd1);
      tick();
      check_wr($sformatf("bp_alu%0d", k), 1'b1, 5'd10, 32'h1000 + 32'(k));
    end
    set_lsu(1'b1, 5'd7, 3'b010, 2'd0, 32'h107);
    #1;
    check("bp_full_ready", {31'd0, lsu_ready}, 32'd0);
    check("bp_full_busy", busy_mask, 32'h00000078);
    tick();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      tick();
      check_wr($sformatf("bp_drain%0d", k), 1'b1, 5'(3 + k), 32'h100 + 32'(k));
    end
    tick();
    check("bp_done_en", {31'd0, write_regf_en}, 32'd0);
    check("bp_done_busy", busy_mask, 32'd0);

    // x0 destinations: handshake completes, queued load takes the port.
    set_alu(1'b1, 5'd1, 32'h11);
    set_lsu(1'b1, 5'd7, 3'b010, 2'd0, 32'h77);
    tick();
    set_alu(1'b1, 5'd0, 32'h99);
    set_lsu(1'b1, 5'd0, 3'b010, 2'd0, 32'hEE);
    #1;
    check("x0_ready", {31'd0, lsu_ready}, 32'd1);
    check("x0_busy_pre", busy_mask, 32'h00000080);
    tick();
    idle_in();
    check_wr("x0_queued", 1'b1, 5'd7, 32'h77);
    check("x0_busy_post", busy_mask, 32'd0);
    tick();
    set_alu(1'b1, 5'd0, 32'h99);
    set_lsu(1'b1, 5'd0, 3'b010, 2'd0, 32'hEE);
    #1;
    check("x0b_ready", {31'd0, lsu_ready}, 32'd1);
    tick();
    idle_in();
    check_wr("x0_nowrite", 1'b0, 5'd7, 32'h77);
    check("x0_busy_nowrite", busy_mask, 32'd0);

    // Full queue with a pop: not accepted that cycle, accepted the next.
    for (int k = 0; k < 4; k++) begin
      set_alu(1'b1, 5'd10, 32'h2000);
      set_lsu(1'b1, 5'(3 + k), 3'b010, 2'd0, 32'h200 + 32'(k));
      tick();
    end
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsu(1'b1, 5'd8, 3'b010, 2'd0, 32'h208);
    #1;
    check("fp_ready_full", {31'd0, lsu_ready}, 32'd0);
    tick();
    check_wr("fp_pop0", 1'b1, 5'd3, 32'h200);
    check("fp_ready_next", {31'd0, lsu_ready}, 32'd1);
    tick();
    idle_in();
    check_wr("fp_pop1", 1'b1, 5'd4, 32'h201);
    check("fp_busy", busy_mask, 32'h00000160);
    tick();
    check_wr("fp_pop2", 1'b1, 5'd5, 32'h202);
    tick();
    check_wr("fp_pop3", 1'b1, 5'd6, 32'h203);
    tick();
    check_wr("fp_pop4", 1'b1, 5'd8, 32'h208);
    tick();
    check("fp_done_en", {31'd0, write_regf_en}, 32'd0);
    check("fp_done_busy", busy_mask, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
